// File: rtl/timer_pkg.sv
// Shared types and constants for the calendar-chain control sequencer:
// state encoding, field indices, field maxima and the wrapped-increment helper.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EDIT = 2'd2
    } state_e;

    localparam logic [2:0] FLD_SEC   = 3'd0;
    localparam logic [2:0] FLD_MIN   = 3'd1;
    localparam logic [2:0] FLD_HOUR  = 3'd2;
    localparam logic [2:0] FLD_DAY   = 3'd3;
    localparam logic [2:0] FLD_MONTH = 3'd4;
    localparam logic [2:0] FLD_YEAR  = 3'd5;

    localparam logic [7:0] MAX_SEC   = 8'd59;
    localparam logic [7:0] MAX_MIN   = 8'd59;
    localparam logic [7:0] MAX_HOUR  = 8'd23;
    localparam logic [7:0] MAX_DAY   = 8'd29;
    localparam logic [7:0] MAX_MONTH = 8'd11;
    localparam logic [7:0] MAX_YEAR  = 8'd10;

    function automatic logic [7:0] field_max(input logic [2:0] sel);
        case (sel)
            FLD_SEC:   field_max = MAX_SEC;
            FLD_MIN:   field_max = MAX_MIN;
            FLD_HOUR:  field_max = MAX_HOUR;
            FLD_DAY:   field_max = MAX_DAY;
            FLD_MONTH: field_max = MAX_MONTH;
            FLD_YEAR:  field_max = MAX_YEAR;
            default:   field_max = 8'd0;
        endcase
    endfunction

    // Out-of-range values (corrupted chain contents) also fold back to zero.
    function automatic logic [7:0] wrap_inc(input logic [2:0] sel, input logic [7:0] val);
        logic [7:0] mx;
        mx = field_max(sel);
        if (val >= mx) begin
            wrap_inc = 8'd0;
        end else begin
            wrap_inc = val + 8'd1;
        end
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Front-panel pulses, chain field values and control outputs of the sequencer.
interface timer_ctrl_if;
    logic       btn_start;
    logic       btn_stop;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_clear;
    logic [7:0] cur_sec;
    logic [7:0] cur_min;
    logic [7:0] cur_hour;
    logic [7:0] cur_day;
    logic [7:0] cur_month;
    logic [7:0] cur_year;
    logic       tick;
    logic       clr;
    logic       ld_en;
    logic [2:0] ld_sel;
    logic [7:0] ld_val;
    logic [1:0] state;
    logic [2:0] edit_sel;

    modport master (
        output btn_start, btn_stop, btn_mode, btn_inc, btn_clear,
        output cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        input  tick, clr, ld_en, ld_sel, ld_val, state, edit_sel
    );

    modport slave (
        input  btn_start, btn_stop, btn_mode, btn_inc, btn_clear,
        input  cur_sec, cur_min, cur_hour, cur_day, cur_month, cur_year,
        output tick, clr, ld_en, ld_sel, ld_val, state, edit_sel
    );
endinterface

// File: rtl/timer_prescaler.sv
// Divides clk into one-second wrap pulses; counts only while enabled, sync clear wins.
module timer_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic sclr,
    output logic wrap
);
    localparam int unsigned          CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_r;

    // Wrap only on an enabled terminal-count cycle, so a held counter never pulses.
    always_comb begin
        if (en && (count_r == CNT_MAX)) begin
            wrap = 1'b1;
        end else begin
            wrap = 1'b0;
        end
    end

    // Counter register: clear, wrap to zero, advance, or hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (sclr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (wrap) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/timer_ctrl.sv
// Start/stop/clear/edit sequencer for the calendar counter chain; every output
// is registered and the time value itself lives in the chain, not here.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic          clk,
    input  logic          reset,
    timer_ctrl_if.slave   bus
);
    state_e     state_r;
    state_e     state_nx_s;
    logic [2:0] edit_sel_r;
    logic [2:0] edit_sel_nx_s;
    logic       clr_nx_s;
    logic       ld_nx_s;
    logic [7:0] field_s;
    logic [7:0] ld_val_nx_s;
    logic       presc_en_s;
    logic       presc_sclr_s;
    logic       wrap_s;
    logic       tick_r;
    logic       clr_r;
    logic       ld_en_r;
    logic [2:0] ld_sel_r;
    logic [7:0] ld_val_r;

    // A stop or clear sampled on the wrap edge freezes the count and drops that tick.
    assign presc_en_s   = (state_r == ST_RUN) && !bus.btn_stop && !bus.btn_clear;
    assign presc_sclr_s = bus.btn_clear;

    timer_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .reset (reset),
        .en    (presc_en_s),
        .sclr  (presc_sclr_s),
        .wrap  (wrap_s)
    );

    // Select the chain field currently under edit.
    always_comb begin
        case (edit_sel_r)
            FLD_SEC:   field_s = bus.cur_sec;
            FLD_MIN:   field_s = bus.cur_min;
            FLD_HOUR:  field_s = bus.cur_hour;
            FLD_DAY:   field_s = bus.cur_day;
            FLD_MONTH: field_s = bus.cur_month;
            FLD_YEAR:  field_s = bus.cur_year;
            default:   field_s = 8'd0;
        endcase
    end

    assign ld_val_nx_s = wrap_inc(edit_sel_r, field_s);

    // Next state: only the highest-priority button acts (clear > stop > start > mode > inc).
    always_comb begin
        state_nx_s    = state_r;
        edit_sel_nx_s = edit_sel_r;
        clr_nx_s      = 1'b0;
        ld_nx_s       = 1'b0;
        if (bus.btn_clear) begin
            clr_nx_s      = 1'b1;
            state_nx_s    = ST_IDLE;
            edit_sel_nx_s = 3'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.btn_stop) begin
                        state_nx_s = ST_IDLE;
                    end else if (bus.btn_start) begin
                        state_nx_s = ST_RUN;
                    end else if (bus.btn_mode) begin
                        state_nx_s    = ST_EDIT;
                        edit_sel_nx_s = 3'd0;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.btn_stop) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                ST_EDIT: begin
                    if (bus.btn_stop) begin
                        state_nx_s    = ST_IDLE;
                        edit_sel_nx_s = 3'd0;
                    end else if (bus.btn_start) begin
                        state_nx_s = ST_EDIT;
                    end else if (bus.btn_mode) begin
                        if (edit_sel_r == FLD_YEAR) begin
                            state_nx_s    = ST_IDLE;
                            edit_sel_nx_s = 3'd0;
                        end else begin
                            edit_sel_nx_s = edit_sel_r + 3'd1;
                        end
                    end else if (bus.btn_inc) begin
                        ld_nx_s = 1'b1;
                    end else begin
                        state_nx_s = ST_EDIT;
                    end
                end
                default: begin
                    state_nx_s    = ST_IDLE;
                    edit_sel_nx_s = 3'd0;
                end
            endcase
        end
    end

    // State and edit-field registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            edit_sel_r <= 3'd0;
        end else begin
            state_r    <= state_nx_s;
            edit_sel_r <= edit_sel_nx_s;
        end
    end

    // Output pulse registers; ld_sel/ld_val keep the last load between pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_r   <= 1'b0;
            clr_r    <= 1'b0;
            ld_en_r  <= 1'b0;
            ld_sel_r <= 3'd0;
            ld_val_r <= 8'd0;
        end else begin
            tick_r  <= wrap_s;
            clr_r   <= clr_nx_s;
            ld_en_r <= ld_nx_s;
            if (ld_nx_s) begin
                ld_sel_r <= edit_sel_r;
                ld_val_r <= ld_val_nx_s;
            end else begin
                ld_sel_r <= ld_sel_r;
                ld_val_r <= ld_val_r;
            end
        end
    end

    assign bus.tick     = tick_r;
    assign bus.clr      = clr_r;
    assign bus.ld_en    = ld_en_r;
    assign bus.ld_sel   = ld_sel_r;
    assign bus.ld_val   = ld_val_r;
    assign bus.state    = state_r;
    assign bus.edit_sel = edit_sel_r;
endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl with TICK_DIV = 4: vector table through a scoreboard
// queue, then hand-written asynchronous-reset sequences.
module tb_timer_ctrl;
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] CLR  = 5'b10000;
    localparam logic [4:0] STP  = 5'b01000;
    localparam logic [4:0] STA  = 5'b00100;
    localparam logic [4:0] MOD  = 5'b00010;
    localparam logic [4:0] INC  = 5'b00001;

    typedef struct {
        string      nm;
        logic [4:0] btn;
        logic [2:0] fld;
        logic [7:0] cur;
        logic [18:0] exp;
    } vec_t;

    typedef struct {
        string       nm;
        logic [18:0] exp;
    } sb_t;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;
    vec_t vt[$];
    sb_t  exp_q[$];

    timer_ctrl_if bus();

    timer_ctrl #(.TICK_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [18:0] outs();
        return {bus.tick, bus.clr, bus.ld_en, bus.ld_sel, bus.ld_val, bus.state, bus.edit_sel};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expected fields: tick, clr, ld_en, ld_sel, ld_val, state, edit_sel after the sampling edge.
    task automatic add(input string nm, input logic [4:0] btn, input logic [2:0] fld, input logic [7:0] cur,
                       input logic tk, input logic cr, input logic ld, input logic [2:0] ls,
                       input logic [7:0] lv, input logic [1:0] st, input logic [2:0] es);
        vec_t v;
        v.nm  = nm;
        v.btn = btn;
        v.fld = fld;
        v.cur = cur;
        v.exp = {tk, cr, ld, ls, lv, st, es};
        vt.push_back(v);
    endtask

    task automatic drive(input logic [4:0] btn, input logic [2:0] fld, input logic [7:0] cur);
        {bus.btn_clear, bus.btn_stop, bus.btn_start, bus.btn_mode, bus.btn_inc} = btn;
        bus.cur_sec   = (fld == 3'd0) ? cur : 8'hEE;
        bus.cur_min   = (fld == 3'd1) ? cur : 8'hEE;
        bus.cur_hour  = (fld == 3'd2) ? cur : 8'hEE;
        bus.cur_day   = (fld == 3'd3) ? cur : 8'hEE;
        bus.cur_month = (fld == 3'd4) ? cur : 8'hEE;
        bus.cur_year  = (fld == 3'd5) ? cur : 8'hEE;
    endtask

    initial begin
        sb_t s;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(NONE, 3'd0, 8'd0);

        // Start, free run, pause/resume, stop on wrap edge, start+stop together.
        add("start",        STA,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        for (int i = 1; i <= 9; i++) begin
            add("run", NONE, 3'd0, 8'd0, (i == 4 || i == 8), 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        end
        add("run_p2",       NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("stop_p2",      STP,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        for (int i = 0; i < 7; i++) begin
            add("paused", NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        end
        add("resume",       STA,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("resume_p3",    NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("resume_tick",  NONE, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            add("run2", NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        end
        add("stop_on_wrap", STP,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        add("restart_p3",   STA,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("held_tick",    NONE, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("start_stop",   STA|STP, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        add("idle_a",       NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        add("idle_b",       NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        add("idle_inc",     INC,  3'd2, 8'd5, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        // Clear while running resets the prescaler.
        add("start3",       STA,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run3_p1",      NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run3_p2",      NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("clear_run",    CLR,  3'd0, 8'd0, 1'b0, 1'b1, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        add("start4",       STA,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run4_p1",      NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run4_p2",      NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run4_p3",      NONE, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run4_tick",    NONE, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run_mode",     MOD,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("run_inc",      INC,  3'd0, 8'd7, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd1, 3'd0);
        add("stop4",        STP,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd0, 3'd0);
        // Edit mode: wrap, out-of-range, normal increments, field walk.
        add("edit_enter",   MOD,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd2, 3'd0);
        add("edit_min",     MOD,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd2, 3'd1);
        add("edit_hour",    MOD,  3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 2'd2, 3'd2);
        add("hour_23",      INC,  3'd2, 8'd23, 1'b0, 1'b0, 1'b1, 3'd2, 8'd0, 2'd2, 3'd2);
        add("hour_40",      INC,  3'd2, 8'd40, 1'b0, 1'b0, 1'b1, 3'd2, 8'd0, 2'd2, 3'd2);
        add("hour_5",       INC,  3'd2, 8'd5,  1'b0, 1'b0, 1'b1, 3'd2, 8'd6, 2'd2, 3'd2);
        add("ld_hold",      NONE, 3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd2, 8'd6, 2'd2, 3'd2);
        add("edit_day",     MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd2, 8'd6, 2'd2, 3'd3);
        add("day_10",       INC,  3'd3, 8'd10, 1'b0, 1'b0, 1'b1, 3'd3, 8'd11, 2'd2, 3'd3);
        add("edit_month",   MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd3, 8'd11, 2'd2, 3'd4);
        add("month_11",     INC,  3'd4, 8'd11, 1'b0, 1'b0, 1'b1, 3'd4, 8'd0, 2'd2, 3'd4);
        add("edit_start",   STA,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd4, 8'd0, 2'd2, 3'd4);
        add("edit_year",    MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd4, 8'd0, 2'd2, 3'd5);
        add("year_9",       INC,  3'd5, 8'd9,  1'b0, 1'b0, 1'b1, 3'd5, 8'd10, 2'd2, 3'd5);
        add("edit_exit",    MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd5, 8'd10, 2'd0, 3'd0);
        add("edit_again",   MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd5, 8'd10, 2'd2, 3'd0);
        add("sec_59",       INC,  3'd0, 8'd59, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0, 2'd2, 3'd0);
        add("sec_58",       INC,  3'd0, 8'd58, 1'b0, 1'b0, 1'b1, 3'd0, 8'd59, 2'd2, 3'd0);
        add("edit_min2",    MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd0, 8'd59, 2'd2, 3'd1);
        add("min_30",       INC,  3'd1, 8'd30, 1'b0, 1'b0, 1'b1, 3'd1, 8'd31, 2'd2, 3'd1);
        add("edit_stop",    STP,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd1, 8'd31, 2'd0, 3'd0);
        // Clear beats start and inc during edit.
        add("edit_enter3",  MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd1, 8'd31, 2'd2, 3'd0);
        add("edit_min3",    MOD,  3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd1, 8'd31, 2'd2, 3'd1);
        add("clear_edit",   CLR|STA|INC, 3'd1, 8'd3, 1'b0, 1'b1, 1'b0, 3'd1, 8'd31, 2'd0, 3'd0);
        add("after_clear",  NONE, 3'd0, 8'd0,  1'b0, 1'b0, 1'b0, 3'd1, 8'd31, 2'd0, 3'd0);

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'(outs()), 32'd0);
        reset = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].btn, vt[i].fld, vt[i].cur);
            s.nm  = vt[i].nm;
            s.exp = vt[i].exp;
            exp_q.push_back(s);
            @(posedge clk);
            #1;
            s = exp_q.pop_front();
            check(s.nm, 32'(outs()), 32'(s.exp));
        end
        drive(NONE, 3'd0, 8'd0);

        // Reset asserted mid-RUN with the prescaler at 2 and a nonzero last load.
        drive(STA, 3'd0, 8'd0);
        @(posedge clk);
        #1;
        drive(NONE, 3'd0, 8'd0);
        repeat (6) @(posedge clk);
        #1;
        check("pre_reset_run", 32'(bus.state), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", 32'(outs()), 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", 32'(outs()), 32'd0);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_reset_idle", 32'(outs()), 32'd0);
        end

        // Fresh start after reset: prescaler back at 0, tick 4 cycles later.
        drive(STA, 3'd0, 8'd0);
        @(posedge clk);
        #1;
        drive(NONE, 3'd0, 8'd0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            check("restart_tick", 32'({bus.tick, bus.state}), 32'({(i == 4), 2'd1}));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
